mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the IF-stage instruction fetch and the MEM-stage load/store unit of the 5-stage RISC-V pipeline.
- Data-side accesses have fixed priority over fetches, with an anti-starvation counter.
- One outstanding transaction at a time; request fields are latched at grant.
- Supports IF flush (taken branch/jump) by discarding an in-flight fetch response.

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_if.sv | 64 ++++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and the arbitration helper for mem_port_arbiter.
// Struct field widths are the package maximums; the arbiter casts its ports onto them.
package mem_arb_pkg;

  localparam int ARB_ADDR_W               = 32;
  localparam int ARB_DATA_W               = 32;
  localparam int ARB_BE_W                 = ARB_DATA_W / 8;
  localparam int ARB_DEFAULT_STARVE_LIMIT = 4;

  localparam logic [ARB_BE_W-1:0] IF_BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  we;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_BE_W-1:0]   be;
  } mem_req_t;

  // Data side wins by default; a pending fetch wins once it has been starved.
  function automatic arb_owner_t pick_winner(input logic dm_req,
                                             input logic if_req,
                                             input logic starved);
    if (if_req && (starved || !dm_req)) return OWN_IF;
    return OWN_DM;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch side, data side and the shared memory port.
// Optional wait counters appear when MEM_ARB_STATS_EN is defined.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_flush;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [31:0]           if_wait_cnt;
  logic [31:0]           dm_wait_cnt;
`endif

  // The arbiter: answers both requesters and masters the memory port.
  modport master (
    input  if_req, if_addr, if_flush,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
`ifdef MEM_ARB_STATS_EN
    , output if_wait_cnt, dm_wait_cnt
`endif
  );

  // The environment: pipeline requesters plus the memory itself.
  modport slave (
    output if_req, if_addr, if_flush,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
`ifdef MEM_ARB_STATS_EN
    , input  if_wait_cnt, dm_wait_cnt
`endif
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit, one
// transaction in flight. Define MEM_ARB_STATS_EN to add per-requester wait counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int STARVE_LIMIT = ARB_DEFAULT_STARVE_LIMIT
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  mem_req_t          req_p1, req_d;
  logic [DATA_W-1:0] if_rdata_p1, dm_rdata_p1;

  logic       rsp_cycle;
  logic       arb_en;
  logic       if_eff;
  logic       starved;
  logic       grant;
  logic       if_gnt_c, dm_gnt_c;
  logic       if_rvalid_c, dm_rvalid_c;
  arb_owner_t winner;

  // A flushed fetch request is treated as absent for this cycle's arbitration.
  assign rsp_cycle = (state_q == WAIT) && bus.mem_rvalid;
  assign arb_en    = !rst && ((state_q == IDLE) || rsp_cycle);
  assign if_eff    = bus.if_req && !bus.if_flush;
  assign starved   = (starve_q == STARVE_MAX);
  assign winner    = pick_winner(bus.dm_req, if_eff, starved);
  assign grant     = arb_en && (bus.dm_req || if_eff);
  assign if_gnt_c  = grant && (winner == OWN_IF);
  assign dm_gnt_c  = grant && (winner == OWN_DM);

  assign if_rvalid_c = rsp_cycle && (owner_q == OWN_IF) && !discard_q && !bus.if_flush;
  assign dm_rvalid_c = rsp_cycle && (owner_q == OWN_DM);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    discard_d = discard_q;
    starve_d  = starve_q;
    req_d     = req_p1;

    case (state_q)
      REQ:     if (bus.mem_ready) state_d = WAIT;
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // The memory still completes a flushed fetch; only its response is dropped.
    if (bus.if_flush && (owner_q == OWN_IF) && (state_q != IDLE) && !rsp_cycle)
      discard_d = 1'b1;

    if (if_gnt_c) begin
      state_d   = REQ;
      owner_d   = OWN_IF;
      discard_d = 1'b0;
      starve_d  = '0;
      req_d     = '{addr:  ARB_ADDR_W'(bus.if_addr),
                    we:    1'b0,
                    wdata: '0,
                    be:    IF_BE_ALL};
    end else if (dm_gnt_c) begin
      state_d   = REQ;
      owner_d   = OWN_DM;
      discard_d = 1'b0;
      if (if_eff && !starved) starve_d = starve_q + CNT_W'(1);
      req_d     = '{addr:  ARB_ADDR_W'(bus.dm_addr),
                    we:    bus.dm_we,
                    wdata: ARB_DATA_W'(bus.dm_wdata),
                    be:    ARB_BE_W'(bus.dm_be)};
    end
  end

  // Grant stage: request fields captured here feed the memory port until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      discard_q   <= 1'b0;
      starve_q    <= '0;
      req_p1      <= '0;
      if_rdata_p1 <= '0;
      dm_rdata_p1 <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      discard_q <= discard_d;
      starve_q  <= starve_d;
      req_p1    <= req_d;
      if (if_rvalid_c) if_rdata_p1 <= bus.mem_rdata;
      if (dm_rvalid_c) dm_rdata_p1 <= bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.if_rvalid = if_rvalid_c;
  assign bus.dm_rvalid = dm_rvalid_c;
  assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : if_rdata_p1;
  assign bus.dm_rdata  = dm_rvalid_c ? bus.mem_rdata : dm_rdata_p1;

  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = req_p1.we;
  assign bus.mem_addr  = ADDR_W'(req_p1.addr);
  assign bus.mem_wdata = DATA_W'(req_p1.wdata);
  assign bus.mem_be    = (DATA_W/8)'(req_p1.be);

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_wait_q, dm_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_wait_q <= '0;
      dm_wait_q <= '0;
    end else begin
      if (bus.if_req && !if_gnt_c && (if_wait_q != '1)) if_wait_q <= if_wait_q + 32'd1;
      if (bus.dm_req && !dm_gnt_c && (dm_wait_q != '1)) dm_wait_q <= dm_wait_q + 32'd1;
    end
  end

  assign bus.if_wait_cnt = if_wait_q;
  assign bus.dm_wait_cnt = dm_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

  typedef enum int {EV_MEM, EV_IFR, EV_DMR, EV_IFG, EV_DMG} ev_t;

  typedef struct {
    ev_t         kind;
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          n_chk;
  int          n_pass;
  int          stall_cycles;
  int          rsp_delay;
  int          mem_waited;
  int          mem_cd;
  int          mon_cyc;
  logic        done;
  exp_t        mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string ev_name(ev_t k);
    case (k)
      EV_MEM:  return "mem_req";
      EV_IFR:  return "if_rvalid";
      EV_DMR:  return "dm_rvalid";
      EV_IFG:  return "if_gnt";
      default: return "dm_gnt";
    endcase
  endfunction

  function automatic void exp_ev(ev_t k, logic [31:0] a = '0, logic we = 1'b0,
                                 logic [31:0] d = '0, logic [3:0] be = '0);
    exp_q.push_back('{k, a, we, d, be});
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, req);
  endfunction

  function automatic void take(ev_t k, logic [31:0] d);
    exp_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: got unexpected event, want none pending", ev_name(k));
      return;
    end
    e = exp_q[0];
    if (e.kind != k) begin
      $display("FAIL %s_order: got %s, want %s", ev_name(k), ev_name(k), ev_name(e.kind));
      return;
    end
    n_pass++;
    void'(exp_q.pop_front());
    if (k == EV_IFR || k == EV_DMR) chk({ev_name(k), "_data"}, 64'(d), 64'(e.data));
  endfunction

  // Memory model: optional ready stall per request, response rsp_delay cycles after accept.
  initial begin
    mem_waited     = 0;
    mem_cd         = 0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (bus.mem_ready) begin
          mem_waited = 0;
          mem_cd     = rsp_delay + 1;
        end else begin
          mem_waited++;
        end
      end
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hFFFF_FFFF;
        end
      end
      bus.mem_ready = (mem_waited >= stall_cycles);
    end
  end

  // Monitor: reset-state checks while rst is high, scoreboard checks otherwise.
  initial begin
    n_chk   = 0;
    n_pass  = 0;
    mon_cyc = 0;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (mon_cyc > 3000) begin
        n_chk++;
        $display("FAIL timeout: got %0d cycles, want done within 3000", mon_cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
      if (rst) begin
        chk("rst_flags", 64'({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_req}), 64'd0);
        chk("rst_mem_ctrl", 64'({bus.mem_we, bus.mem_be, bus.mem_addr}), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 64'd0);
      end else begin
        if (bus.mem_req) begin
          if (exp_q.size() == 0 || exp_q[0].kind != EV_MEM) begin
            n_chk++;
            $display("FAIL mem_req: got request addr %h, want no request", bus.mem_addr);
          end else begin
            mon_e = exp_q[0];
            chk("mem_ctrl", 64'({bus.mem_we, bus.mem_be, bus.mem_addr}),
                64'({mon_e.we, mon_e.be, mon_e.addr}));
            if (mon_e.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(mon_e.data));
            if (bus.mem_ready) void'(exp_q.pop_front());
          end
        end
        if (bus.if_rvalid) take(EV_IFR, bus.if_rdata);
        if (bus.dm_rvalid) take(EV_DMR, bus.dm_rdata);
        if (bus.if_gnt)    take(EV_IFG, '0);
        if (bus.dm_gnt)    take(EV_DMG, '0);
        if (bus.if_gnt || bus.dm_gnt)
          chk("gnt_onehot", 64'(bus.if_gnt & bus.dm_gnt), 64'd0);
        if (bus.if_rvalid || bus.dm_rvalid)
          chk("rvalid_onehot", 64'(bus.if_rvalid & bus.dm_rvalid), 64'd0);
      end
      if (done) begin
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    done         = 1'b0;
    stall_cycles = 0;
    rsp_delay    = 0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    bus.dm_be    = '0;
    rst          = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single fetch
    exp_ev(EV_IFG);
    exp_ev(EV_MEM, 32'h0000_0004, 1'b0, '0, 4'hF);
    exp_ev(EV_IFR, '0, 1'b0, 32'h0040_2283);
    rsp_q.push_back(32'h0040_2283);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0004;
    tick;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'hFFFF_FFF0;
    tick(4);

    // Simultaneous requests: data first, fetch granted on the response cycle
    exp_ev(EV_DMG);
    exp_ev(EV_MEM, 32'h0000_0008, 1'b0, '0, 4'hF);
    exp_ev(EV_DMR, '0, 1'b0, 32'hDEAD_BEEF);
    exp_ev(EV_IFG);
    exp_ev(EV_MEM, 32'h0000_0010, 1'b0, '0, 4'hF);
    exp_ev(EV_IFR, '0, 1'b0, 32'h0000_0013);
    rsp_q.push_back(32'hDEAD_BEEF);
    rsp_q.push_back(32'h0000_0013);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0008;
    bus.dm_be   = 4'hF;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    tick;
    bus.dm_req = 1'b0;
    tick(2);
    bus.if_req = 1'b0;
    tick(4);

    // Starvation: four data grants, one fetch grant, then data again
    for (int k = 1; k <= 4; k++) begin
      exp_ev(EV_DMG);
      exp_ev(EV_MEM, 32'h0000_0100, 1'b0, '0, 4'hF);
      exp_ev(EV_DMR, '0, 1'b0, 32'h0000_1000 + k);
      rsp_q.push_back(32'h0000_1000 + k);
    end
    exp_ev(EV_IFG);
    exp_ev(EV_MEM, 32'h0000_0200, 1'b0, '0, 4'hF);
    exp_ev(EV_IFR, '0, 1'b0, 32'h0000_2001);
    exp_ev(EV_DMG);
    exp_ev(EV_MEM, 32'h0000_0100, 1'b0, '0, 4'hF);
    exp_ev(EV_DMR, '0, 1'b0, 32'h0000_1005);
    rsp_q.push_back(32'h0000_2001);
    rsp_q.push_back(32'h0000_1005);
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0100;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    tick(11);
    bus.dm_req = 1'b0;
    bus.if_req = 1'b0;
    tick(4);

    // Store with three cycles of backpressure; requester inputs change after grant
    stall_cycles = 3;
    tick;
    exp_ev(EV_DMG);
    exp_ev(EV_MEM, 32'h0000_0004, 1'b1, 32'h0000_00FF, 4'hF);
    exp_ev(EV_DMR, '0, 1'b0, 32'h0000_0000);
    rsp_q.push_back(32'h0000_0000);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0004;
    bus.dm_wdata = 32'h0000_00FF;
    bus.dm_be    = 4'hF;
    tick;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0000_BAD0;
    bus.dm_wdata = 32'h1234_5678;
    bus.dm_be    = 4'h1;
    tick(6);
    stall_cycles = 0;
    tick(2);

    // Flush while the fetch waits for its response
    rsp_delay = 2;
    tick;
    exp_ev(EV_IFG);
    exp_ev(EV_MEM, 32'h0000_0040, 1'b0, '0, 4'hF);
    rsp_q.push_back(32'hBADB_AD00);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    tick;
    bus.if_req = 1'b0;
    tick;
    bus.if_flush = 1'b1;
    tick;
    bus.if_flush = 1'b0;
    rsp_delay    = 0;
    tick(2);

    // Flush coinciding with a fetch request in IDLE blocks the grant for that cycle
    exp_ev(EV_IFG);
    exp_ev(EV_MEM, 32'h0000_0044, 1'b0, '0, 4'hF);
    exp_ev(EV_IFR, '0, 1'b0, 32'h00A0_0093);
    rsp_q.push_back(32'h00A0_0093);
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0044;
    bus.if_flush = 1'b1;
    tick;
    bus.if_flush = 1'b0;
    tick;
    bus.if_req = 1'b0;
    tick(3);

    // Asynchronous reset mid-WAIT, then a stray response after release
    rsp_delay = 3;
    tick;
    exp_ev(EV_IFG);
    exp_ev(EV_MEM, 32'h0000_0080, 1'b0, '0, 4'hF);
    rsp_q.push_back(32'h5555_AAAA);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0080;
    tick;
    bus.if_req = 1'b0;
    tick;
    #2;
    rst = 1'b1;
    tick;
    rst       = 1'b0;
    rsp_delay = 0;
    tick(5);

    // Normal load after recovery
    exp_ev(EV_DMG);
    exp_ev(EV_MEM, 32'h0000_000C, 1'b0, '0, 4'h3);
    exp_ev(EV_DMR, '0, 1'b0, 32'hCAFE_F00D);
    rsp_q.push_back(32'hCAFE_F00D);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_000C;
    bus.dm_be   = 4'h3;
    tick;
    bus.dm_req = 1'b0;
    tick(4);
    done = 1'b1;
  end

endmodule
